// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32I load/store execution. Drives a single-outstanding
//               req/ack data bus with byte strobes and replicated store data,
//               and returns aligned, sign/zero-extended load data.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic        is_lb_i,
  input  logic        is_lh_i,
  input  logic        is_lw_i,
  input  logic        is_lbu_i,
  input  logic        is_lhu_i,
  input  logic        is_sb_i,
  input  logic        is_sh_i,
  input  logic        is_sw_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Loads are encoded below stores so "is load" is a single compare.
  localparam logic [3:0] OP_LB   = 4'd0;
  localparam logic [3:0] OP_LH   = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_LBU  = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_SB   = 4'd5;
  localparam logic [3:0] OP_SH   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_NONE = 4'd8;

  // Counter only needs to reach TIMEOUT-1; the abort fires on that cycle.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [1:0]       off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      maddr_q, maddr_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      ldata_q, ldata_d;
  logic             mis_q, mis_d;
  logic             err_q, err_d;

  logic [3:0]       op_w;
  logic             mis_w;
  logic [3:0]       wstrb_w;
  logic [31:0]      wdata_w;
  logic [31:0]      ext_w;
  logic [7:0]       byte_w;
  logic [15:0]      half_w;

  // Priority decode of the op flags plus natural-alignment check.
  always_comb begin
    op_w = OP_NONE;
    if (is_lb_i)       op_w = OP_LB;
    else if (is_lh_i)  op_w = OP_LH;
    else if (is_lw_i)  op_w = OP_LW;
    else if (is_lbu_i) op_w = OP_LBU;
    else if (is_lhu_i) op_w = OP_LHU;
    else if (is_sb_i)  op_w = OP_SB;
    else if (is_sh_i)  op_w = OP_SH;
    else if (is_sw_i)  op_w = OP_SW;
    case (op_w)
      OP_LH, OP_LHU, OP_SH: mis_w = addr_i[0];
      OP_LW, OP_SW:         mis_w = |addr_i[1:0];
      default:              mis_w = 1'b0;
    endcase
  end

  // Store byte lanes and replicated write data (loads drive no strobes).
  always_comb begin
    wstrb_w = 4'b0000;
    wdata_w = 32'h0;
    case (op_w)
      OP_SB: begin
        wstrb_w = 4'b0001 << addr_i[1:0];
        wdata_w = {4{store_data_i[7:0]}};
      end
      OP_SH: begin
        wstrb_w = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_w = {2{store_data_i[15:0]}};
      end
      OP_SW: begin
        wstrb_w = 4'b1111;
        wdata_w = store_data_i;
      end
      default: ;
    endcase
  end

  // Lane extraction and extension of the returned read word.
  always_comb begin
    byte_w = mem_rdata_i[{off_q, 3'b000} +: 8];
    half_w = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
    case (op_q)
      OP_LB:   ext_w = {{24{byte_w[7]}}, byte_w};
      OP_LH:   ext_w = {{16{half_w[15]}}, half_w};
      OP_LW:   ext_w = mem_rdata_i;
      OP_LBU:  ext_w = {24'h0, byte_w};
      OP_LHU:  ext_w = {16'h0, half_w};
      default: ext_w = 32'h0;
    endcase
  end

  // Next-state logic: IDLE -> REQ -> RESP -> IDLE, or IDLE -> RESP on no-op/misalign.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    maddr_d = maddr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    mis_d   = mis_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (lsu_valid_i) begin
          op_d  = op_w;
          off_d = addr_i[1:0];
          cnt_d = '0;
          if (op_w == OP_NONE) begin
            state_d = S_RESP;
          end else if (mis_w) begin
            mis_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            req_d   = 1'b1;
            we_d    = (op_w >= OP_SB);
            maddr_d = {addr_i[31:2], 2'b00};
            wstrb_d = wstrb_w;
            wdata_d = wdata_w;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (mem_ack_i || ((TIMEOUT != 0) && (cnt_q == TO_LAST))) begin
          ldata_d = (mem_ack_i && !we_q) ? ext_w : 32'h0;
          err_d   = !mem_ack_i;
          req_d   = 1'b0;
          we_d    = 1'b0;
          maddr_d = 32'h0;
          wstrb_d = 4'b0000;
          wdata_d = 32'h0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        ldata_d = 32'h0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      off_q   <= 2'b00;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= 32'h0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0;
      ldata_q <= 32'h0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign lsu_ready_o  = (state_q == S_IDLE);
  assign done_o       = (state_q == S_RESP);
  assign mem_req_o    = req_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = maddr_q;
  assign mem_wstrb_o  = wstrb_q;
  assign mem_wdata_o  = wdata_q;
  assign load_data_o  = ldata_q;
  assign misaligned_o = mis_q;
  assign bus_err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        is_lb = 0, is_lh = 0, is_lw = 0, is_lbu = 0;
  logic        is_lhu = 0, is_sb = 0, is_sh = 0, is_sw = 0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        done, misaligned, bus_err;
  logic [31:0] load_data;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready),
    .addr_i(addr), .store_data_i(store_data),
    .is_lb_i(is_lb), .is_lh_i(is_lh), .is_lw_i(is_lw), .is_lbu_i(is_lbu),
    .is_lhu_i(is_lhu), .is_sb_i(is_sb), .is_sh_i(is_sh), .is_sw_i(is_sw),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wstrb_o(mem_wstrb), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .done_o(done), .load_data_o(load_data),
    .misaligned_o(misaligned), .bus_err_o(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ops();
    {is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw} = 8'h00;
  endtask

  // Present one request for a single cycle; returns in cycle T+1.
  task automatic issue(input logic [7:0] flags, input logic [31:0] a, input logic [31:0] sd);
    {is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw} = flags;
    addr = a;
    store_data = sd;
    lsu_valid = 1'b1;
    chk("ready_at_accept", {31'h0, lsu_ready}, 32'h1);
    tick();
    lsu_valid = 1'b0;
    clr_ops();
  endtask

  localparam logic [7:0] F_LB  = 8'b1000_0000;
  localparam logic [7:0] F_LH  = 8'b0100_0000;
  localparam logic [7:0] F_LW  = 8'b0010_0000;
  localparam logic [7:0] F_LHU = 8'b0000_1000;
  localparam logic [7:0] F_SB  = 8'b0000_0100;
  localparam logic [7:0] F_SH  = 8'b0000_0010;
  localparam logic [7:0] F_SW  = 8'b0000_0001;

  initial begin
    #3;
    chk("rst_ready", {31'h0, lsu_ready}, 32'h1);
    chk("rst_req",   {31'h0, mem_req}, 32'h0);
    chk("rst_addr",  mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_done",  {31'h0, done}, 32'h0);
    chk("rst_ldata", load_data, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // lb 0x1003, ack on first request cycle
    issue(F_LB, 32'h1003, 32'h0);
    chk("lb_req",   {31'h0, mem_req}, 32'h1);
    chk("lb_we",    {31'h0, mem_we}, 32'h0);
    chk("lb_addr",  mem_addr, 32'h1000);
    chk("lb_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("lb_done_early", {31'h0, done}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h80123456;
    tick();
    mem_ack = 1'b0;
    chk("lb_done",  {31'h0, done}, 32'h1);
    chk("lb_data",  load_data, 32'hFFFFFF80);
    chk("lb_req_drop", {31'h0, mem_req}, 32'h0);
    chk("lb_ready_resp", {31'h0, lsu_ready}, 32'h0);
    tick();
    chk("lb_done_pulse", {31'h0, done}, 32'h0);
    chk("lb_ldata_clr", load_data, 32'h0);

    // lhu / lh at 0x2002
    issue(F_LHU, 32'h2002, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hBEEF1234;
    tick();
    mem_ack = 1'b0;
    chk("lhu_data", load_data, 32'h0000BEEF);
    tick();
    issue(F_LH, 32'h2002, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hBEEF1234;
    tick();
    mem_ack = 1'b0;
    chk("lh_data", load_data, 32'hFFFFBEEF);
    tick();

    // sh 0x102 with ack on third request cycle
    issue(F_SH, 32'h102, 32'h0000CAFE);
    mem_rdata = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      chk("sh_req",   {31'h0, mem_req}, 32'h1);
      chk("sh_we",    {31'h0, mem_we}, 32'h1);
      chk("sh_addr",  mem_addr, 32'h100);
      chk("sh_wstrb", {28'h0, mem_wstrb}, 32'hC);
      chk("sh_wdata", mem_wdata, 32'hCAFECAFE);
      if (c == 2) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("sh_done",  {31'h0, done}, 32'h1);
    chk("sh_ldata", load_data, 32'h0);
    chk("sh_berr",  {31'h0, bus_err}, 32'h0);
    tick();

    // sb 0x7: top lane strobe and byte replication; lb beats sw in priority
    issue(F_SB, 32'h7, 32'h12345678);
    chk("sb_wstrb", {28'h0, mem_wstrb}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'h78787878);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    issue(F_LB | F_SW, 32'h0, 32'hFFFFFFFF);
    chk("prio_we", {31'h0, mem_we}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h0000007F;
    tick();
    mem_ack = 1'b0;
    chk("prio_data", load_data, 32'h0000007F);
    tick();

    // misaligned lw
    issue(F_LW, 32'h101, 32'h0);
    chk("mis_req",  {31'h0, mem_req}, 32'h0);
    chk("mis_done", {31'h0, done}, 32'h1);
    chk("mis_flag", {31'h0, misaligned}, 32'h1);
    tick();
    chk("mis_ready", {31'h0, lsu_ready}, 32'h1);
    chk("mis_clr",   {31'h0, misaligned}, 32'h0);

    // no op flag set
    issue(8'h00, 32'h40, 32'h0);
    chk("nop_done", {31'h0, done}, 32'h1);
    chk("nop_mis",  {31'h0, misaligned}, 32'h0);
    chk("nop_req",  {31'h0, mem_req}, 32'h0);
    tick();

    // timeout: sw 0x10, no ack
    issue(F_SW, 32'h10, 32'h11223344);
    for (int c = 0; c < 4; c++) begin
      chk("to_req", {31'h0, mem_req}, 32'h1);
      tick();
    end
    chk("to_req_drop", {31'h0, mem_req}, 32'h0);
    chk("to_done",  {31'h0, done}, 32'h1);
    chk("to_berr",  {31'h0, bus_err}, 32'h1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_ready", {31'h0, lsu_ready}, 32'h1);
    chk("late_ack_done",  {31'h0, done}, 32'h0);
    chk("late_ack_req",   {31'h0, mem_req}, 32'h0);
    chk("late_berr_clr",  {31'h0, bus_err}, 32'h0);

    // reset during REQ
    issue(F_LB, 32'h4, 32'h0);
    chk("rr_req", {31'h0, mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_req_drop", {31'h0, mem_req}, 32'h0);
    chk("rr_ready",    {31'h0, lsu_ready}, 32'h1);
    tick();
    rst_n = 1'b1;
    tick();
    issue(F_LB, 32'h5, 32'h0);
    chk("rr_addr", mem_addr, 32'h4);
    mem_ack = 1'b1; mem_rdata = 32'h0000F000;
    tick();
    mem_ack = 1'b0;
    chk("rr_done", {31'h0, done}, 32'h1);
    chk("rr_data", load_data, 32'hFFFFFFF0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
